// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_pkg
// Purpose  : Shared types, constants and helpers for the Mastermind grader.
// Revision : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    // One shape code; 0 is the "no shape" value
    typedef logic [2:0] shape_t;

    // Number of positions in a pattern
    localparam int NUM_POS = 4;

    // Code that never names a real shape
    localparam shape_t SHAPE_NONE = 3'd0;

    // Width of the red/white/total counters (holds 0..4)
    localparam int CNT_W = 3;

    // Grading sequence
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RED   = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } grader_state_t;

    // A code is a real shape when it lies in 1..max_shape
    function automatic logic is_valid_shape(input shape_t s, input shape_t max_shape);
        return (s != SHAPE_NONE) && (s <= max_shape);
    endfunction

endpackage : mastermind_pkg
`default_nettype wire

// File: rtl/mastermind_grader_shape_tally.sv
`default_nettype none
// ============================================================================
// Module   : shape_tally
// Purpose  : Counts how many of four shape codes equal a given colour.
//            Purely combinational; result is 0..4.
// Revision : 1.0 - initial release
// ============================================================================
module shape_tally
    import mastermind_pkg::*;
(
    input  shape_t             s0,
    input  shape_t             s1,
    input  shape_t             s2,
    input  shape_t             s3,
    input  shape_t             color,
    output logic [CNT_W-1:0]   count
);

    // Sum of the four per-position equality flags
    always_comb begin
        count = CNT_W'(s0 == color)
              + CNT_W'(s1 == color)
              + CNT_W'(s2 == color)
              + CNT_W'(s3 == color);
    end

endmodule : shape_tally
`default_nettype wire

// File: rtl/mastermind_grader.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_grader
// Purpose  : Serial Mastermind grader. On start, latches the guess and master
//            patterns, counts exact matches over 4 cycles, tallies per-colour
//            minimum counts over NUM_SHAPES cycles, then presents red/white
//            with a one-cycle done pulse. Latency is 4+NUM_SHAPES+1 cycles.
//            Optional macro GRADER_INVALID_CHECK_EN adds an "invalid" output
//            that forces red=white=0 when any latched code is out of range.
// Revision : 1.0 - initial release
// ============================================================================
module mastermind_grader
    import mastermind_pkg::*;
#(
    parameter int NUM_SHAPES = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  shape_t             guess0,
    input  shape_t             guess1,
    input  shape_t             guess2,
    input  shape_t             guess3,
    input  shape_t             master0,
    input  shape_t             master1,
    input  shape_t             master2,
    input  shape_t             master3,
`ifdef GRADER_INVALID_CHECK_EN
    output logic               invalid,
`endif
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   red,
    output logic [CNT_W-1:0]   white
);

    localparam shape_t LAST_COLOR = shape_t'(NUM_SHAPES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    grader_state_t      state_q,   state_d;
    shape_t             idx_q,     idx_d;      // position in RED, colour in COLOR
    logic [CNT_W-1:0]   red_acc_q, red_acc_d;
    logic [CNT_W-1:0]   tot_acc_q, tot_acc_d;
    shape_t             guess_q  [NUM_POS];
    shape_t             guess_d  [NUM_POS];
    shape_t             master_q [NUM_POS];
    shape_t             master_d [NUM_POS];
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [CNT_W-1:0]   red_q,     red_d;
    logic [CNT_W-1:0]   white_q,   white_d;
`ifdef GRADER_INVALID_CHECK_EN
    logic               inv_acc_q, inv_acc_d;
    logic               invalid_q, invalid_d;
    logic               any_invalid;
`endif

    // ------------------------------------------------------------------
    // Per-colour tallies of the latched patterns (colour = idx_q)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   guess_cnt;
    logic [CNT_W-1:0]   master_cnt;
    logic [CNT_W-1:0]   min_cnt;
    shape_t             cur_guess;
    shape_t             cur_master;

    shape_tally u_guess_tally (
        .s0    (guess_q[0]),
        .s1    (guess_q[1]),
        .s2    (guess_q[2]),
        .s3    (guess_q[3]),
        .color (idx_q),
        .count (guess_cnt)
    );

    shape_tally u_master_tally (
        .s0    (master_q[0]),
        .s1    (master_q[1]),
        .s2    (master_q[2]),
        .s3    (master_q[3]),
        .color (idx_q),
        .count (master_cnt)
    );

    // Position-select and colour-minimum datapath
    always_comb begin
        cur_guess  = guess_q[idx_q[1:0]];
        cur_master = master_q[idx_q[1:0]];
        min_cnt    = (guess_cnt < master_cnt) ? guess_cnt : master_cnt;
    end

`ifdef GRADER_INVALID_CHECK_EN
    // Any out-of-range code among the eight latched codes
    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (!is_valid_shape(guess_q[i], LAST_COLOR) ||
                !is_valid_shape(master_q[i], LAST_COLOR)) begin
                any_invalid = 1'b1;
            end
        end
    end
`endif

    // Next-state and datapath control for the grading sequence
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        red_acc_d = red_acc_q;
        tot_acc_d = tot_acc_q;
        guess_d   = guess_q;
        master_d  = master_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        red_d     = red_q;
        white_d   = white_q;
`ifdef GRADER_INVALID_CHECK_EN
        inv_acc_d = inv_acc_q;
        invalid_d = invalid_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    guess_d[0]  = guess0;
                    guess_d[1]  = guess1;
                    guess_d[2]  = guess2;
                    guess_d[3]  = guess3;
                    master_d[0] = master0;
                    master_d[1] = master1;
                    master_d[2] = master2;
                    master_d[3] = master3;
                    idx_d       = '0;
                    red_acc_d   = '0;
                    tot_acc_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = RED;
`ifdef GRADER_INVALID_CHECK_EN
                    inv_acc_d   = 1'b0;
`endif
                end
            end

            RED: begin
                // Exact match only counts when the shared code is a real shape
                if ((cur_guess == cur_master) && is_valid_shape(cur_guess, LAST_COLOR)) begin
                    red_acc_d = red_acc_q + 1'b1;
                end
`ifdef GRADER_INVALID_CHECK_EN
                if (idx_q == 3'd0) begin
                    inv_acc_d = any_invalid;
                end
`endif
                if (idx_q == shape_t'(NUM_POS - 1)) begin
                    idx_d   = 3'd1;          // colour scan starts at first real shape
                    state_d = COLOR;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end

            COLOR: begin
                tot_acc_d = tot_acc_q + min_cnt;
                if (idx_q == LAST_COLOR) begin
                    // Load results on the edge into DONE so they are valid with done
                    done_d  = 1'b1;
                    red_d   = red_acc_q;
                    white_d = tot_acc_d - red_acc_q;
`ifdef GRADER_INVALID_CHECK_EN
                    invalid_d = inv_acc_q;
                    if (inv_acc_q) begin
                        red_d   = '0;
                        white_d = '0;
                    end
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            red_acc_q <= '0;
            tot_acc_q <= '0;
            for (int i = 0; i < NUM_POS; i++) begin
                guess_q[i]  <= SHAPE_NONE;
                master_q[i] <= SHAPE_NONE;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            red_q     <= '0;
            white_q   <= '0;
`ifdef GRADER_INVALID_CHECK_EN
            inv_acc_q <= 1'b0;
            invalid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            red_acc_q <= red_acc_d;
            tot_acc_q <= tot_acc_d;
            guess_q   <= guess_d;
            master_q  <= master_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            red_q     <= red_d;
            white_q   <= white_d;
`ifdef GRADER_INVALID_CHECK_EN
            inv_acc_q <= inv_acc_d;
            invalid_q <= invalid_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign red   = red_q;
    assign white = white_q;
`ifdef GRADER_INVALID_CHECK_EN
    assign invalid = invalid_q;
`endif

endmodule : mastermind_grader
`default_nettype wire

// File: doc/mastermind_grader.md
Name: mastermind_grader

Overview:
Sequential grader that scores one Mastermind guess against the master pattern. It produces the red (exact position) and white (right shape, wrong position) counts consumed by the feedback/peg-display logic.
It sits between the guess-entry/master-pattern registers and the feedback decoder, and grades serially to keep comparator area small.
It uses a start/done handshake at fixed latency.

Parameters:
NUM_SHAPES, 6, number of valid shape codes; valid codes are 3'd1..NUM_SHAPES; legal range 1..7.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request grading; sampled only in IDLE
guess0..guess3  input  3 each  guess shape codes, position 0..3
master0..master3  input  3 each  master shape codes, position 0..3
busy  output  1  high from cycle after accepted start through DONE cycle
done  output  1  one-cycle pulse; red/white valid from this cycle
red  output  3  exact-match count, 0..4
white  output  3  shape-only match count, 0..4; red+white <= 4

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy=0, done=0, red=0, white=0; internal counters and latched patterns cleared. Reset during any state aborts grading with no done pulse.
- IDLE: start=1 latches all eight codes into internal registers and moves to RED. Inputs may change after the accepting edge.
- RED: 4 cycles, position index p=0..3. If g[p]==m[p] and the code is valid, red_acc increments. After p=3, move to COLOR.
- COLOR: NUM_SHAPES cycles, color c=1..NUM_SHAPES. tot_acc += min(count of c in guess, count of c in master). After the last c, move to DONE.
- DONE: 1 cycle. Registered outputs load red=red_acc and white=tot_acc-red_acc. done=1, busy=1. Next state is IDLE.
- Latency: start accepted at edge 0, so done is high in cycle 4+NUM_SHAPES+1 (cycle 11 at default). Fixed and data-independent.
- red/white hold their values until the next DONE or reset. They never glitch during grading.
- start while busy (RED/COLOR/DONE) is ignored, with no queueing. start in IDLE the cycle after DONE is accepted normally.
- Invalid codes (0 or >NUM_SHAPES) never contribute to red or to the color tally. tot_acc >= red_acc therefore always holds, so the subtraction never underflows.
- Accumulators are 3 bits wide and saturate by construction (max 4).

Optional Feature:
Macro GRADER_INVALID_CHECK_EN.
- Defined: adds output port invalid (1 bit). It is computed from the latched codes in the first RED cycle. If any code is invalid, DONE reports red=0, white=0, invalid=1, with the same latency.
- invalid resets to 0 and holds like red/white.
- Not defined: no invalid port. Invalid codes are handled as described under Behaviour.

Decomposition:
- Package mastermind_pkg:
  - shape_t (logic [2:0]);
  - NUM_POS=4;
  - SHAPE_NONE=3'd0;
  - grader_state_t enum {IDLE, RED, COLOR, DONE};
  - count width constant CNT_W=3.
- One combinational sub-module, shape_tally: takes four shape_t and a color, returns the occurrence count (0..4). It is instantiated twice (guess and master) and drives the COLOR step.

Test Plan:
- Reset held 2 cycles, then guess=1,2,3,4 master=1,2,3,4, start pulsed -> busy high cycles 1..11, done only in cycle 11, red=4 white=0.
- guess=1,2,3,4 master=4,3,2,1 -> red=0 white=4. guess=1,1,2,2 master=1,2,1,3 -> red=1 white=2. guess=5,5,5,5 master=5,6,6,6 -> red=1 white=0.
- start re-pulsed in cycles 3 and 11 with different codes -> both ignored, and the outputs of the first grading persist. start in cycle 12 -> accepted, done in cycle 23.
- reset asserted in cycle 5 of a grading -> next cycle busy=0, red=0, white=0, no done. A subsequent start grades normally.
- guess=0,1,2,3 master=0,1,2,3: without macro -> red=3 white=0. With GRADER_INVALID_CHECK_EN -> invalid=1 red=0 white=0 at cycle 11.
- Change guess/master inputs every cycle during grading -> result equals the grade of the values latched at start.
